// File: rtl/gsim_pkg.sv
// Shared types and constants for the GSIM sequencer slice.
package gsim_pkg;

  localparam int N_ROWS = 16;
  localparam int ROW_W  = 4;
  localparam int ITER_W = 8;
  localparam int DATA_W = 32;
  localparam int B_W    = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [B_W-1:0]    b_t;
  typedef logic [ROW_W-1:0]  row_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } state_e;

  typedef struct packed {
    data_t p1;
    data_t p2;
    data_t p3;
    data_t m1;
    data_t m2;
    data_t m3;
  } taps_t;

  // Neighbour row index; the 4-bit add wraps mod 16 on its own.
  function automatic row_t tap_idx(input row_t i, input int off);
    tap_idx = i + row_t'(off);
  endfunction

endpackage

// File: rtl/gsim_if.sv
// Sequencer-facing bus: b load, datapath issue/return and result stream.
interface gsim_if
  import gsim_pkg::*;
();
  logic  in_en;
  b_t    b_in;
  logic  busy;
  logic  dp_valid;
  row_t  dp_count;
  b_t    dp_b;
  data_t dp_p1, dp_p2, dp_p3;
  data_t dp_m1, dp_m2, dp_m3;
  logic  dp_x_valid;
  data_t dp_x;
  logic  out_valid;
  data_t x_out;

  modport slave (
    input  in_en, b_in, dp_x_valid, dp_x,
    output busy, dp_valid, dp_count, dp_b,
           dp_p1, dp_p2, dp_p3, dp_m1, dp_m2, dp_m3,
           out_valid, x_out
  );

  modport master (
    output in_en, b_in, dp_x_valid, dp_x,
    input  busy, dp_valid, dp_count, dp_b,
           dp_p1, dp_p2, dp_p3, dp_m1, dp_m2, dp_m3,
           out_valid, x_out
  );
endinterface

// File: rtl/gsim_xfile.sv
// 16-entry x register file: one write port, six wrapped tap reads, one stream read.
module gsim_xfile
  import gsim_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  we_i,
  input  row_t  waddr_i,
  input  data_t wdata_i,
  input  row_t  tap_row_i,
  output taps_t taps_o,
  input  row_t  raddr_i,
  output data_t rdata_o
);

  data_t mem_q [N_ROWS];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < N_ROWS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Taps are sent wrapped; boundary masking belongs to the datapath.
  assign taps_o.p1 = mem_q[tap_idx(tap_row_i,  1)];
  assign taps_o.p2 = mem_q[tap_idx(tap_row_i,  2)];
  assign taps_o.p3 = mem_q[tap_idx(tap_row_i,  3)];
  assign taps_o.m1 = mem_q[tap_idx(tap_row_i, -1)];
  assign taps_o.m2 = mem_q[tap_idx(tap_row_i, -2)];
  assign taps_o.m3 = mem_q[tap_idx(tap_row_i, -3)];

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gsim_ctrl.sv
// GSIM sequencer: loads b, issues rows to the datapath in Gauss-Seidel order,
// writes results back in place and streams x after N_ITER sweeps.
module gsim_ctrl
  import gsim_pkg::*;
#(
  parameter int N_ITER = 16
) (
  input logic   clk,
  input logic   rst,
  gsim_if.slave bus
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

  state_e            state_q, state_d;
  row_t              row_q, row_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              busy_q, busy_d;
  logic              dp_valid_q, dp_valid_d;
  row_t              dp_count_q, dp_count_d;
  b_t                dp_b_q, dp_b_d;
  taps_t             taps_q, taps_d;
  logic              out_valid_q, out_valid_d;
  data_t             x_out_q, x_out_d;

  b_t    b_q [N_ROWS];
  logic  b_we, x_we, x_clr;
  row_t  b_waddr;
  taps_t taps_rd;
  data_t x_rd;

  gsim_xfile u_xfile (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (x_clr),
    .we_i      (x_we),
    .waddr_i   (row_q),
    .wdata_i   (bus.dp_x),
    .tap_row_i (row_q),
    .taps_o    (taps_rd),
    .raddr_i   (row_q),
    .rdata_o   (x_rd)
  );

  assign b_waddr = (state_q == IDLE) ? '0 : row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ROWS; i++) b_q[i] <= '0;
    end else if (b_we) begin
      b_q[b_waddr] <= bus.b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_count_q  <= '0;
      dp_b_q      <= '0;
      taps_q      <= '0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      iter_q      <= iter_d;
      busy_q      <= busy_d;
      dp_valid_q  <= dp_valid_d;
      dp_count_q  <= dp_count_d;
      dp_b_q      <= dp_b_d;
      taps_q      <= taps_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    iter_d      = iter_q;
    busy_d      = busy_q;
    dp_valid_d  = 1'b0;
    dp_count_d  = dp_count_q;
    dp_b_d      = dp_b_q;
    taps_d      = taps_q;
    out_valid_d = 1'b0;
    x_out_d     = '0;
    b_we        = 1'b0;
    x_we        = 1'b0;
    x_clr       = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.in_en) begin
          b_we    = 1'b1;
          x_clr   = 1'b1;
          row_d   = row_t'(1);
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.in_en) begin
          b_we  = 1'b1;
          row_d = row_q + 1'b1;
          if (row_q == row_t'(N_ROWS - 1)) begin
            iter_d  = '0;
            state_d = ISSUE;
          end
        end
      end
      // Taps are sampled here, one cycle after the previous row's write,
      // so m1 always carries the freshly updated neighbour.
      ISSUE: begin
        dp_valid_d = 1'b1;
        dp_count_d = row_q;
        dp_b_d     = b_q[row_q];
        taps_d     = taps_rd;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.dp_x_valid) begin
          x_we  = 1'b1;
          row_d = row_q + 1'b1;
          if (row_q == row_t'(N_ROWS - 1) && iter_q == LAST_ITER) begin
            state_d = OUTPUT;
          end else begin
            if (row_q == row_t'(N_ROWS - 1)) iter_d = iter_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      OUTPUT: begin
        out_valid_d = 1'b1;
        x_out_d     = x_rd;
        row_d       = row_q + 1'b1;
        if (row_q == row_t'(N_ROWS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_count  = dp_count_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.dp_p1     = taps_q.p1;
  assign bus.dp_p2     = taps_q.p2;
  assign bus.dp_p3     = taps_q.p3;
  assign bus.dp_m1     = taps_q.m1;
  assign bus.dp_m2     = taps_q.m2;
  assign bus.dp_m3     = taps_q.m3;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;

endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed bench: two sequencers (N_ITER=1 and N_ITER=2) behind a b<<16 datapath model.
module tb_gsim_ctrl;
  import gsim_pkg::*;

  localparam int STALL_LEN = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_en, spur, clr;
  b_t   b_in;
  b_t   bv [16];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  gsim_if if1 ();
  gsim_if if2 ();

  gsim_ctrl #(.N_ITER(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  gsim_ctrl #(.N_ITER(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic  dpv [2], ov [2], dxv [2];
  row_t  dpc [2];
  b_t    dpb [2];
  taps_t tp  [2];
  data_t xo  [2], dx [2];

  assign if1.in_en = in_en;
  assign if2.in_en = in_en;
  assign if1.b_in  = b_in;
  assign if2.b_in  = b_in;
  assign if1.dp_x_valid = dxv[0] | spur;
  assign if2.dp_x_valid = dxv[1] | spur;
  assign if1.dp_x = spur ? 32'hDEAD_BEEF : dx[0];
  assign if2.dp_x = spur ? 32'hDEAD_BEEF : dx[1];

  assign dpv[0] = if1.dp_valid;  assign dpv[1] = if2.dp_valid;
  assign dpc[0] = if1.dp_count;  assign dpc[1] = if2.dp_count;
  assign dpb[0] = if1.dp_b;      assign dpb[1] = if2.dp_b;
  assign ov[0]  = if1.out_valid; assign ov[1]  = if2.out_valid;
  assign xo[0]  = if1.x_out;     assign xo[1]  = if2.x_out;
  assign tp[0]  = {if1.dp_p1, if1.dp_p2, if1.dp_p3, if1.dp_m1, if1.dp_m2, if1.dp_m3};
  assign tp[1]  = {if2.dp_p1, if2.dp_p2, if2.dp_p3, if2.dp_m1, if2.dp_m2, if2.dp_m3};

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: x = b<<16 returned 3 cycles after dp_valid (longer on the stall row).
  int cd [2] = '{0, 0};
  int stall_row [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dpv[i])
        cd[i] <= 3 + ((int'(dpc[i]) == stall_row[i]) ? STALL_LEN : 0);
      else if (cd[i] > 0)
        cd[i] <= cd[i] - 1;
      dxv[i] <= !dpv[i] && (cd[i] == 1);
      dx[i]  <= {dpb[i], 16'h0000};
    end
  end

  int    issues [2], gap_bad [2], last_iss [2], unstable [2], cnt7 [2], ov_gap [2], last_out [2];
  logic  inflight [2];
  row_t  held_c [2];
  b_t    held_b [2];
  taps_t held_t [2];
  taps_t tap_log [2][64];
  row_t  cnt_log [2][64];
  data_t outq [2][$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        issues[i] <= 0; gap_bad[i] <= 0; unstable[i] <= 0; cnt7[i] <= 0;
        ov_gap[i] <= 0; inflight[i] <= 1'b0;
        outq[i].delete();
      end else begin
        if (rst) begin
          inflight[i] <= 1'b0;
        end else if (dpv[i]) begin
          held_c[i] <= dpc[i]; held_b[i] <= dpb[i]; held_t[i] <= tp[i];
          inflight[i] <= 1'b1;
        end else if (inflight[i]) begin
          if (dpc[i] != held_c[i] || dpb[i] != held_b[i] || tp[i] != held_t[i])
            unstable[i] <= unstable[i] + 1;
          if (dxv[i]) inflight[i] <= 1'b0;
        end
        if (dpv[i]) begin
          if (issues[i] < 64) begin
            tap_log[i][issues[i]] <= tp[i];
            cnt_log[i][issues[i]] <= dpc[i];
          end
          if (issues[i] > 0 && cyc - last_iss[i] != 5) gap_bad[i] <= gap_bad[i] + 1;
          if (dpc[i] == row_t'(7)) cnt7[i] <= cnt7[i] + 1;
          last_iss[i] <= cyc;
          issues[i]   <= issues[i] + 1;
        end
        if (ov[i]) begin
          if (outq[i].size() > 0 && cyc != last_out[i] + 1) ov_gap[i] <= ov_gap[i] + 1;
          outq[i].push_back(xo[i]);
          last_out[i] <= cyc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
    @(negedge clk);
  endtask

  // Streams bv[0..15]; optional in_en gap before gap_at, with spurious dp_x_valid inside it.
  task automatic load(input int gap_at, input int gap_len);
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at) begin
        in_en = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          spur = (g < 2);
          @(negedge clk);
        end
        spur = 1'b0;
        chk("busy_in_gap", if1.busy, 1'b1);
      end
      in_en = 1'b1;
      b_in  = bv[k];
      @(negedge clk);
    end
    in_en = 1'b0;
    b_in  = '0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((if1.busy || if2.busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < max), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_stream(input string tag, input int d);
    chk({tag, "_count"}, outq[d].size(), 16);
    chk({tag, "_contig"}, ov_gap[d], 0);
    for (int k = 0; k < 16; k++)
      chk(tag, (k < outq[d].size()) ? outq[d][k] : 'x, {bv[k], 16'h0000});
  endtask

  initial begin
    int n;
    rst = 1'b1; in_en = 1'b0; b_in = '0; spur = 1'b0; clr = 1'b0;
    stall_row = '{-1, -1};
    repeat (3) @(negedge clk);
    chk("rst_busy",     if1.busy, 1'b0);
    chk("rst_dp_valid", if1.dp_valid, 1'b0);
    chk("rst_dp_count", if1.dp_count, 4'd0);
    chk("rst_dp_m1",    if1.dp_m1, 32'd0);
    chk("rst_out",      {if1.out_valid, if1.x_out}, 33'd0);
    rst = 1'b0;
    clear_mon();

    // Run 1: b[i]=i, gapless load.
    for (int k = 0; k < 16; k++) bv[k] = b_t'(k);
    load(-1, 0);
    wait_idle(600);
    chk_stream("r1_x_n1", 0);
    chk("r1_issues_n1", issues[0], 16);
    chk("r1_period_n1", gap_bad[0], 0);
    chk_stream("r1_x_n2", 1);
    chk("r1_issues_n2", issues[1], 32);
    chk("r1_period_n2", gap_bad[1], 0);
    chk("r1_s1r0_taps",  tap_log[1][0], '0);
    chk("r1_s1r5_m1",    tap_log[1][5].m1, 32'h0004_0000);
    chk("r1_s1r5_p1",    tap_log[1][5].p1, 32'h0);
    chk("r1_s2r0_p1",    tap_log[1][16].p1, 32'h0001_0000);
    chk("r1_s2r0_p3",    tap_log[1][16].p3, 32'h0003_0000);
    chk("r1_s2r0_m1",    tap_log[1][16].m1, 32'h000F_0000);
    chk("r1_s2r0_m2",    tap_log[1][16].m2, 32'h000E_0000);
    chk("r1_s2r0_m3",    tap_log[1][16].m3, 32'h000D_0000);
    chk("r1_s2r1_count", cnt_log[1][17], 4'd1);

    // Run 2: gapped load with spurious returns, row-7 stall with in_en during WAIT.
    clear_mon();
    for (int k = 0; k < 16; k++) bv[k] = b_t'(3 * k - 20);
    stall_row[0] = 7;
    load(5, 7);
    n = 0;
    while (!(if1.dp_count == 4'd7 && if1.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("r2_row7_timeout", (n < 200), 1'b1);
    repeat (3) @(negedge clk);
    in_en = 1'b1; b_in = 16'h7FFF;
    repeat (3) @(negedge clk);
    in_en = 1'b0; b_in = '0;
    wait_idle(800);
    stall_row[0] = -1;
    chk_stream("r2_x_n1", 0);
    chk("r2_issues_n1", issues[0], 16);
    chk("r2_row7_once", cnt7[0], 1);
    chk("r2_stable",    unstable[0], 0);
    chk_stream("r2_x_n2", 1);
    chk("r2_issues_n2", issues[1], 32);
    chk("r2_s1r4_p1",   tap_log[1][4].p1, 32'h0);
    chk("r2_s2r0_m1",   tap_log[1][16].m1, {bv[15], 16'h0000});

    // Run 3: reset on row 9 of the first sweep, then a fresh all-zero load.
    clear_mon();
    for (int k = 0; k < 16; k++) bv[k] = b_t'(k + 1);
    load(-1, 0);
    n = 0;
    while (issues[0] < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("r3_row9_timeout", (n < 200), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("r3_busy",      {if1.busy, if2.busy}, 2'b00);
    chk("r3_dp_valid",  if1.dp_valid, 1'b0);
    chk("r3_dp_count",  if1.dp_count, 4'd0);
    chk("r3_dp_b",      if1.dp_b, 16'd0);
    chk("r3_taps",      tp[0], '0);
    chk("r3_out",       {if1.out_valid, if1.x_out}, 33'd0);
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 16; k++) bv[k] = '0;
    load(-1, 0);
    wait_idle(600);
    chk_stream("r3_x_n1", 0);
    chk("r3_issues_n1", issues[0], 16);
    chk_stream("r3_x_n2", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
